// File: rtl/numdiff_pkg.sv
// Shared types, defaults and saturation helpers for the numerical differentiator.
package numdiff_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } state_e;

  localparam int unsigned N_DEFAULT    = 64;
  localparam int unsigned RATE_DEFAULT = 100;

  // Working width for saturation; must cover N+1+clog2(RATE+1) for every supported build.
  localparam int unsigned WIDE_W = 128;

  function automatic logic signed [WIDE_W-1:0] sat_hi(input int unsigned n);
    return (WIDE_W'(1) <<< (n - 1)) - WIDE_W'(1);
  endfunction

  function automatic logic signed [WIDE_W-1:0] sat_n(
    input logic signed [WIDE_W-1:0] v,
    input logic signed [WIDE_W-1:0] hi,
    input logic signed [WIDE_W-1:0] lo
  );
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/numerical_differentiator_if.sv
// Sample-in / derivative-out bundle of the numerical differentiator.
interface numerical_differentiator_if
  import numdiff_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
);
  logic                enable;
  logic                sample_valid;
  logic signed [N-1:0] sample_in;
  logic signed [N-1:0] deriv_out;
  logic                deriv_valid;
  logic                primed;
  logic                sat_flag;

  modport master (
    output enable, sample_valid, sample_in,
    input  deriv_out, deriv_valid, primed, sat_flag
  );

  modport slave (
    input  enable, sample_valid, sample_in,
    output deriv_out, deriv_valid, primed, sat_flag
  );
endinterface

// File: rtl/numdiff_smooth.sv
// Four-tap moving average over the raw derivative stream; output = floor(sum/4).
module numdiff_smooth #(
  parameter int unsigned N = 64
) (
  input  logic                clk,
  input  logic                resetb,
  input  logic                clear,
  input  logic                in_valid,
  input  logic signed [N-1:0] in_data,
  output logic signed [N-1:0] out_data,
  output logic                out_valid
);
  localparam int unsigned SW = N + 2;

  // Three previous raw values; the incoming one completes the four-entry window.
  logic signed [N-1:0]  win_q [3];
  logic [1:0]           fill_q;
  logic signed [SW-1:0] sum_c;

  always_comb begin
    sum_c = SW'(in_data) + SW'(win_q[0]) + SW'(win_q[1]) + SW'(win_q[2]);
  end

  always_ff @(posedge clk or posedge resetb) begin
    if (resetb) begin
      win_q[0]  <= '0;
      win_q[1]  <= '0;
      win_q[2]  <= '0;
      fill_q    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (clear) begin
        win_q[0] <= '0;
        win_q[1] <= '0;
        win_q[2] <= '0;
        fill_q   <= '0;
      end else if (in_valid) begin
        win_q[2] <= win_q[1];
        win_q[1] <= win_q[0];
        win_q[0] <= in_data;
        if (fill_q == 2'd3) begin
          out_data  <= N'(sum_c >>> 2);
          out_valid <= 1'b1;
        end else begin
          fill_q <= fill_q + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/numerical_differentiator.sv
// Backward-difference differentiator: deriv = (x[n]-x[n-1])*RATE saturated to N bits.
// Define NUMDIFF_SMOOTH_EN to add a 4-tap moving average on the output (latency 2).
module numerical_differentiator
  import numdiff_pkg::*;
#(
  parameter int unsigned N    = N_DEFAULT,
  parameter int unsigned RATE = RATE_DEFAULT
) (
  input logic                       clk,
  input logic                       resetb,
  numerical_differentiator_if.slave bus
);
  localparam int unsigned DW = N + 1;
  localparam int unsigned PW = N + 1 + $clog2(RATE + 1);
  localparam logic signed [PW-1:0]     RATE_S = PW'(RATE);
  localparam logic signed [WIDE_W-1:0] SAT_HI = sat_hi(N);
  localparam logic signed [WIDE_W-1:0] SAT_LO = ~SAT_HI;

  state_e              state_q, state_d;
  logic signed [N-1:0] prev_q, prev_d;
  logic signed [N-1:0] raw_q, raw_d;
  logic                raw_valid_q, raw_valid_d;
  logic                primed_q, primed_d;
  logic                sat_q, sat_d;

  logic signed [DW-1:0]     diff_c;
  logic signed [PW-1:0]     prod_c;
  logic signed [WIDE_W-1:0] wide_c, clip_c;

  // Difference and scale at full precision, then clip to the output range.
  always_comb begin
    diff_c = DW'(bus.sample_in) - DW'(prev_q);
    prod_c = PW'(diff_c) * RATE_S;
    wide_c = WIDE_W'(prod_c);
    clip_c = sat_n(wide_c, SAT_HI, SAT_LO);
  end

  // Next state; a low enable overrides everything and flushes history.
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    raw_d       = raw_q;
    raw_valid_d = 1'b0;
    primed_d    = primed_q;
    sat_d       = sat_q;
    if (!bus.enable) begin
      state_d  = IDLE;
      prev_d   = '0;
      primed_d = 1'b0;
      sat_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = PRIME;
        PRIME: begin
          if (bus.sample_valid) begin
            prev_d   = bus.sample_in;
            primed_d = 1'b1;
            state_d  = RUN;
          end
        end
        RUN: begin
          if (bus.sample_valid) begin
            prev_d      = bus.sample_in;
            raw_d       = N'(clip_c);
            raw_valid_d = 1'b1;
            if (clip_c != wide_c) sat_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge resetb) begin
    if (resetb) begin
      state_q     <= IDLE;
      prev_q      <= '0;
      raw_q       <= '0;
      raw_valid_q <= 1'b0;
      primed_q    <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      raw_q       <= raw_d;
      raw_valid_q <= raw_valid_d;
      primed_q    <= primed_d;
      sat_q       <= sat_d;
    end
  end

`ifdef NUMDIFF_SMOOTH_EN
  logic signed [N-1:0] smooth_out;
  logic                smooth_valid;

  numdiff_smooth #(.N(N)) u_smooth (
    .clk      (clk),
    .resetb   (resetb),
    .clear    (~bus.enable),
    .in_valid (raw_valid_q),
    .in_data  (raw_q),
    .out_data (smooth_out),
    .out_valid(smooth_valid)
  );

  assign bus.deriv_out   = smooth_out;
  assign bus.deriv_valid = smooth_valid;
`else
  assign bus.deriv_out   = raw_q;
  assign bus.deriv_valid = raw_valid_q;
`endif

  assign bus.primed   = primed_q;
  assign bus.sat_flag = sat_q;

endmodule

// File: tb/tb_numerical_differentiator.sv
// Directed bench for numerical_differentiator (N=16) with a per-cycle reference model.
module tb_numerical_differentiator;
  localparam int unsigned N = 16;
`ifdef NUMDIFF_SMOOTH_EN
  localparam int unsigned RATE = 1;
`else
  localparam int unsigned RATE = 100;
`endif

  logic clk = 1'b0;
  logic resetb = 1'b1;
  always #5 clk = ~clk;

  numerical_differentiator_if #(.N(N)) dif ();
  numerical_differentiator #(.N(N), .RATE(RATE)) dut (
    .clk   (clk),
    .resetb(resetb),
    .bus   (dif)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Reference model state
  longint m_prev = 0;
  longint m_out = 0;
  bit     m_active = 1'b0;
  bit     m_have_prev = 1'b0;
  bit     m_valid = 1'b0;
  bit     m_sat = 1'b0;
  longint m_win[$];
  bit     m_pend_v = 1'b0;
  longint m_pend = 0;

  function automatic longint clip(input longint v);
    longint hi, lo;
    hi = (longint'(1) <<< (N - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  always @(posedge clk or posedge resetb) begin
    if (resetb) begin
      m_prev = 0; m_out = 0; m_active = 1'b0; m_have_prev = 1'b0;
      m_valid = 1'b0; m_sat = 1'b0; m_win.delete(); m_pend_v = 1'b0; m_pend = 0;
    end else begin
      longint s, d, r;
      s = longint'(dif.sample_in);
      m_valid = 1'b0;
`ifdef NUMDIFF_SMOOTH_EN
      if (m_pend_v && dif.enable) begin
        m_valid = 1'b1;
        m_out   = m_pend;
      end
      m_pend_v = 1'b0;
`endif
      if (!dif.enable) begin
        m_active = 1'b0; m_have_prev = 1'b0; m_prev = 0; m_sat = 1'b0; m_win.delete();
      end else if (!m_active) begin
        m_active = 1'b1;
      end else if (dif.sample_valid) begin
        if (m_have_prev) begin
          d = (s - m_prev) * longint'(RATE);
          r = clip(d);
          if (r != d) m_sat = 1'b1;
`ifdef NUMDIFF_SMOOTH_EN
          m_win.push_back(r);
          if (m_win.size() > 4) void'(m_win.pop_front());
          if (m_win.size() == 4) begin
            m_pend_v = 1'b1;
            m_pend   = (m_win[0] + m_win[1] + m_win[2] + m_win[3]) >>> 2;
          end
`else
          m_out   = r;
          m_valid = 1'b1;
`endif
        end
        m_prev      = s;
        m_have_prev = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic signed [N-1:0] eo;
      eo = N'(m_out);
      n_tests++;
      if (dif.deriv_out !== eo || dif.deriv_valid !== m_valid ||
          dif.primed !== m_have_prev || dif.sat_flag !== m_sat) begin
        n_fail++;
        $display("FAIL model_cycle t=%0t: got out=%0d valid=%0b primed=%0b sat=%0b, want out=%0d valid=%0b primed=%0b sat=%0b",
                 $time, dif.deriv_out, dif.deriv_valid, dif.primed, dif.sat_flag,
                 eo, m_valid, m_have_prev, m_sat);
      end
    end
  end

  task automatic check(input string name, input longint eo, input bit ev, input bit ep, input bit es);
    logic signed [N-1:0] e;
    e = N'(eo);
    n_tests++;
    if (dif.deriv_out !== e || dif.deriv_valid !== ev || dif.primed !== ep || dif.sat_flag !== es) begin
      n_fail++;
      $display("FAIL %s: got out=%0d valid=%0b primed=%0b sat=%0b, want out=%0d valid=%0b primed=%0b sat=%0b",
               name, dif.deriv_out, dif.deriv_valid, dif.primed, dif.sat_flag, e, ev, ep, es);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input longint v);
    dif.sample_valid = 1'b1;
    dif.sample_in    = N'(v);
    tick();
    dif.sample_valid = 1'b0;
  endtask

  task automatic restart();
    dif.enable = 1'b0;
    tick();
    dif.enable = 1'b1;
    tick();
  endtask

  initial begin
    dif.enable       = 1'b0;
    dif.sample_valid = 1'b0;
    dif.sample_in    = '0;
    tick();
    tick();
    check("reset", 0, 1'b0, 1'b0, 1'b0);
    resetb = 1'b0;
    chk_en = 1'b1;
    dif.enable = 1'b1;
    tick();
`ifdef NUMDIFF_SMOOTH_EN
    send(0);   check("sm_s1", 0, 1'b0, 1'b1, 1'b0);
    send(0);   check("sm_s2", 0, 1'b0, 1'b1, 1'b0);
    send(400); check("sm_s3", 0, 1'b0, 1'b1, 1'b0);
    send(400); check("sm_s4", 0, 1'b0, 1'b1, 1'b0);
    send(400); check("sm_s5_latency", 0, 1'b0, 1'b1, 1'b0);
    tick();    check("sm_first", 100, 1'b1, 1'b1, 1'b0);
    tick();    check("sm_gap", 100, 1'b0, 1'b1, 1'b0);
    send(800); tick(); check("sm_next", 200, 1'b1, 1'b1, 1'b0);
    send(0);
    send(1);   check("sm_neg", -100, 1'b1, 1'b1, 1'b0);
    tick();    check("sm_floor", -100, 1'b1, 1'b1, 1'b0);
    restart();
    send(0); send(4); send(8);
    send(12);  check("sm_refill_wait", -100, 1'b0, 1'b1, 1'b0);
    send(16);  tick(); check("sm_refill", 4, 1'b1, 1'b1, 1'b0);
`else
    send(1000); check("prime_first", 0, 1'b0, 1'b1, 1'b0);
    send(1010); check("ramp1", 1000, 1'b1, 1'b1, 1'b0);
    send(1030); check("ramp2", 2000, 1'b1, 1'b1, 1'b0);
    tick();     check("ramp_gap", 2000, 1'b0, 1'b1, 1'b0);

    restart();
    send(500);  check("descent_prime", 2000, 1'b0, 1'b1, 1'b0);
    send(480);  check("descent", -2000, 1'b1, 1'b1, 1'b0);

    restart();
    send(-32768); check("sat_prime", -2000, 1'b0, 1'b1, 1'b0);
    send(32767);  check("sat_hi", 32767, 1'b1, 1'b1, 1'b1);
    send(-32768); check("sat_lo", -32768, 1'b1, 1'b1, 1'b1);

    restart();
    send(100);  check("drop_prime", -32768, 1'b0, 1'b1, 1'b0);
    send(200);  check("drop_run", 10000, 1'b1, 1'b1, 1'b0);
    dif.enable = 1'b0; tick(); check("drop_idle", 10000, 1'b0, 1'b0, 1'b0);
    dif.enable = 1'b1; tick(); check("drop_reenable", 10000, 1'b0, 1'b0, 1'b0);
    send(1000); check("drop_reprime", 10000, 1'b0, 1'b1, 1'b0);
    send(1001); check("drop_out", 100, 1'b1, 1'b1, 1'b0);

    dif.enable = 1'b0; tick();
    dif.enable = 1'b1; dif.sample_valid = 1'b1; dif.sample_in = N'(5000);
    tick();
    dif.sample_valid = 1'b0;
    check("rise_ignored", 100, 1'b0, 1'b0, 1'b0);
    send(5010); check("rise_prime", 100, 1'b0, 1'b1, 1'b0);
    send(5020); check("rise_out", 1000, 1'b1, 1'b1, 1'b0);

    dif.enable = 1'b0; dif.sample_valid = 1'b1; dif.sample_in = N'(9999);
    tick();
    dif.sample_valid = 1'b0;
    check("fall_ignored", 1000, 1'b0, 1'b0, 1'b0);

    dif.enable = 1'b1; tick();
    send(10);
    send(20); check("pre_reset", 1000, 1'b1, 1'b1, 1'b0);
    tick();
    #2 resetb = 1'b1;
    #1 check("async_reset", 0, 1'b0, 1'b0, 1'b0);
    tick();
    resetb = 1'b0;
    tick();
    send(30); check("post_reset_prime", 0, 1'b0, 1'b1, 1'b0);
    send(50); check("post_reset_out", 2000, 1'b1, 1'b1, 1'b0);
`endif
    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/numerical_differentiator.md
Name: numerical_differentiator

Overview:
- Inverse of the altitude integrator: turns a stream of fixed-point altitude samples into a rate-of-change (vertical velocity) stream.
- Uses a backward difference scaled by the sample rate: out = (x[n] - x[n-1]) * RATE, saturated to N bits.
- Sits beside the integrator in the altitude datapath. Consumes sampled sensor/altitude words; feeds velocity to downstream control and display logic.

Parameters:
- N, 64: signed sample and result width (two's complement, same fixed-point format in and out).
- RATE, 100: samples per second (e.g. 10 ms period -> 100); integer multiplier applied to each difference, >= 1.

Ports:
- clk  input  1  system clock, rising-edge.
- resetb  input  1  reset; asynchronous, active-high (1 = in reset).
- enable  input  1  level enable; low flushes history.
- sample_valid  input  1  strobe: sample_in holds a new sample this cycle.
- sample_in  input  N  signed altitude sample.
- deriv_out  output  N  signed scaled difference (saturated).
- deriv_valid  output  1  one-cycle pulse: deriv_out updated.
- primed  output  1  history register holds a valid previous sample.
- sat_flag  output  1  sticky: a saturation occurred since the last IDLE entry.

Behaviour:
- Reset (async, active-high): state=IDLE, prev=0, deriv_out=0, deriv_valid=0, primed=0, sat_flag=0.
- accept = enable & sample_valid & (state != IDLE).
- States:
  - IDLE: enable=1 -> PRIME next cycle. Samples arriving while in IDLE are ignored, including the cycle enable rises.
  - PRIME: on accept, prev<=sample_in, primed<=1, -> RUN. No output.
  - RUN: on accept:
    - diff = sample_in - prev, computed at N+1 bits.
    - prod = diff*RATE, computed at N+1+clog2(RATE+1) bits.
    - Saturate prod to [-2^(N-1), 2^(N-1)-1].
    - deriv_out<=result, deriv_valid<=1 on the next edge (latency 1 cycle).
    - prev<=sample_in.
    - If clipped, sat_flag<=1.
  - Any state, enable=0: -> IDLE next cycle, prev<=0, primed<=0, sat_flag<=0. deriv_out holds its last value.
- enable=0 takes priority: a sample coincident with enable falling is not accepted.
- Back-to-back accepts on every cycle are supported; each produces one deriv_valid pulse.
- deriv_valid is 0 in every cycle not directly following a RUN accept.
- Reset mid-stream: takes effect immediately. History is lost; after release, re-prime before any output.

Optional Feature:
- Macro: NUMDIFF_SMOOTH_EN.
- Defined:
  - The saturated raw derivative feeds a 4-entry moving window, N+2-bit sum.
  - deriv_out = sum >>> 2 (arithmetic shift, floor).
  - deriv_valid pulses only once the window holds 4 raw values since priming, i.e. from the 5th accepted sample on.
  - Latency 2 cycles from accept.
  - Window is cleared on reset and on IDLE entry.
- Undefined: raw derivative output, latency 1; no window logic is synthesized.

Decomposition:
- Package numdiff_pkg:
  - state enum {IDLE, PRIME, RUN};
  - default RATE constant;
  - saturation limit constants derived from N;
  - a function sat_n() that clips a wide signed value to N bits.
- One sub-module: numdiff_smooth, the 4-tap moving-average window, instantiated only under NUMDIFF_SMOOTH_EN.

Test Plan:
- Prime and ramp. RATE=100; reset, enable=1, samples 1000, 1010, 1030 -> no pulse after 1000; deriv_out=1000 then 2000, each deriv_valid one cycle after its sample; primed=1 after first sample.
- Descent. Samples 500, 480 -> deriv_out=-2000; sat_flag=0.
- Saturation. N=16, RATE=100; samples -32768, 32767 -> deriv_out=32767, sat_flag=1. Then sample -32768 -> deriv_out=-32768, sat_flag stays 1.
- Enable drop. Samples 100, 200 (out=10000); drop enable 1 cycle, re-enable; samples 1000, 1001 -> no pulse for 1000, primed=0 during IDLE, then deriv_out=100; sat_flag cleared.
- Async reset. Assert resetb mid-stream between samples -> deriv_out=0 and deriv_valid=0 immediately, state IDLE. First sample after release and re-enable only primes.
- Smoothing (NUMDIFF_SMOOTH_EN, RATE=1). Samples 0, 0, 400, 400, 400 -> no output until the 5th sample; then window holds raw {0, 400, 0, 0} and deriv_out=100 two cycles after the 5th sample.
